alu_rr_scheduler: RTL and testbench

//  Shares one combinational 4-bit basicALU between NUM_REQ requesters.

---
 rtl/alu_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU between NUM_REQ requesters.
// Optional op counter output enabled by defining ALU_SCHED_OPCNT_EN.
module alu_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned OP_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W:0]           resp_data,
    output logic [DATA_W-1:0]         alu_a_out,
    output logic [DATA_W-1:0]         alu_b_out,
    output logic [OP_W-1:0]           alu_sel_out,
    input  logic [DATA_W:0]           alu_y_in,
    output logic                      busy
`ifdef ALU_SCHED_OPCNT_EN
    ,
    output logic [15:0]               op_count
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] gnt_sel;
    logic             gnt_found;
    int unsigned      cand;

    // Round-robin search: first pending requester at or above ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(ptr) + k) % NUM_REQ;
            if (!gnt_found && req_valid[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_sel   = IDX_W'(cand);
            end
        end
    end

    // Next-state and handshake decode; ready is held low while in reset.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                if (rst_n && gnt_found) begin
                    req_ready[gnt_sel] = 1'b1;
                    state_nxt          = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp_valid[grant] = 1'b1;
                if (resp_ready[grant]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on grant, result capture after the ALU settles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            grant       <= '0;
            alu_a_out   <= '0;
            alu_b_out   <= '0;
            alu_sel_out <= '0;
            resp_data   <= '0;
        end else begin
            if (state == IDLE && gnt_found) begin
                alu_a_out   <= req_a[32'(gnt_sel)*DATA_W +: DATA_W];
                alu_b_out   <= req_b[32'(gnt_sel)*DATA_W +: DATA_W];
                alu_sel_out <= req_op[32'(gnt_sel)*OP_W +: OP_W];
                grant       <= gnt_sel;
                ptr         <= (gnt_sel == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_sel + IDX_W'(1);
            end
            if (state == EXEC) begin
                resp_data <= alu_y_in;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef ALU_SCHED_OPCNT_EN
    // Saturating count of completed response handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (state == RESP && resp_ready[grant] && op_count != 16'hFFFF) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: directed and randomized transactions against a reference model.
module tb_alu_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int OW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*OW-1:0] req_op;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [DW:0]     resp_data;
    logic [DW-1:0]   alu_a_out;
    logic [DW-1:0]   alu_b_out;
    logic [OW-1:0]   alu_sel_out;
    logic [DW:0]     alu_y_in;
    logic            busy;
`ifdef ALU_SCHED_OPCNT_EN
    logic [15:0]     op_count;
    int              cnt_m = 0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int ptr_m       = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .alu_a_out   (alu_a_out),
        .alu_b_out   (alu_b_out),
        .alu_sel_out (alu_sel_out),
        .alu_y_in    (alu_y_in),
        .busy        (busy)
`ifdef ALU_SCHED_OPCNT_EN
        ,
        .op_count    (op_count)
`endif
    );

    // Golden model of the shared basicALU.
    function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OW-1:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {1'b0, b};
        endcase
    endfunction

    assign alu_y_in = alu_fn(alu_a_out, alu_b_out, alu_sel_out);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first pending index at or after p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OW-1:0] op);
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
        req_op[i*OW +: OW] = op;
    endtask

    task automatic check_count();
`ifdef ALU_SCHED_OPCNT_EN
        chk("op_count", 32'(op_count), 32'(cnt_m));
`endif
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '1;
        resp_ready = '1;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_alu_a", 32'(alu_a_out), 0);
        chk("rst_alu_b", 32'(alu_b_out), 0);
        chk("rst_alu_sel", 32'(alu_sel_out), 0);
        chk("rst_busy", 32'(busy), 0);
        ptr_m = 0;
`ifdef ALU_SCHED_OPCNT_EN
        cnt_m = 0;
`endif
        check_count();
        req_valid = '0;
        rst_n     = 1'b1;
        tick();
    endtask

    // One full transaction starting in IDLE; resp_ready of the grantee held low for 'stall' RESP cycles.
    task automatic serve(input logic [N-1:0] vmask, input logic [N-1:0] other_rr, input int stall);
        int            g;
        logic [N-1:0]  oh;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        logic [OW-1:0] eop;
        logic [DW:0]   ey;
        g = rr_pick(vmask, ptr_m);
        if (g < 0) return;
        oh     = '0;
        oh[g]  = 1'b1;
        ea     = req_a[g*DW +: DW];
        eb     = req_b[g*DW +: DW];
        eop    = req_op[g*OW +: OW];
        ey     = alu_fn(ea, eb, eop);
        req_valid  = vmask;
        resp_ready = other_rr & ~oh;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'(oh));
        chk("idle_busy", 32'(busy), 0);
        tick();
        ptr_m = (g + 1) % N;
        chk("exec_busy", 32'(busy), 1);
        chk("exec_req_ready", 32'(req_ready), 0);
        chk("exec_resp_valid", 32'(resp_valid), 0);
        chk("exec_alu_a", 32'(alu_a_out), 32'(ea));
        chk("exec_alu_b", 32'(alu_b_out), 32'(eb));
        chk("exec_alu_sel", 32'(alu_sel_out), 32'(eop));
        tick();
        for (int s = 0; s < stall; s++) begin
            chk("stall_resp_valid", 32'(resp_valid), 32'(oh));
            chk("stall_resp_data", 32'(resp_data), 32'(ey));
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_alu_a", 32'(alu_a_out), 32'(ea));
            tick();
        end
        resp_ready = other_rr | oh;
        chk("resp_valid", 32'(resp_valid), 32'(oh));
        chk("resp_data", 32'(resp_data), 32'(ey));
        chk("resp_req_ready", 32'(req_ready), 0);
        tick();
`ifdef ALU_SCHED_OPCNT_EN
        if (cnt_m < 16'hFFFF) cnt_m++;
`endif
        chk("done_busy", 32'(busy), 0);
        chk("done_resp_valid", 32'(resp_valid), 0);
        chk("done_alu_a_hold", 32'(alu_a_out), 32'(ea));
        chk("done_alu_sel_hold", 32'(alu_sel_out), 32'(eop));
        check_count();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;

        // Reset with all requests pending.
        do_reset();

        // Single add on requester 0: 9 + 8 = 0x11.
        set_op(0, 4'h9, 4'h8, 3'd0);
        chk("golden_add", 32'(alu_fn(4'h9, 4'h8, 3'd0)), 32'h11);
        serve(4'b0001, 4'b0001, 0);
        req_valid = '0;

        // Idle cycles: no grants, ALU inputs hold.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_no_ready", 32'(req_ready), 0);
            chk("idle_hold_a", 32'(alu_a_out), 32'h9);
            chk("idle_not_busy", 32'(busy), 0);
        end

        // Round-robin with all requesters pending, distinct ops.
        do_reset();
        set_op(0, 4'h3, 4'h5, 3'd0);
        set_op(1, 4'hC, 4'h4, 3'd1);
        set_op(2, 4'hA, 4'h6, 3'd4);
        set_op(3, 4'hF, 4'h1, 3'd6);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 32'(rr_pick(4'hF, ptr_m)), 32'(i % N));
            serve(4'hF, 4'hF, 0);
        end
        req_valid = '0;

        // Backpressure on requester 1 for 5 cycles.
        set_op(1, 4'h7, 4'h2, 3'd5);
        serve(4'b0010, 4'b1101, 5);
        req_valid = '0;

        // Reset while in EXEC drops the op; pointer returns to 0.
        set_op(2, 4'h6, 4'h3, 3'd3);
        req_valid = 4'b0100;
        #1;
        chk("mid_req_ready", 32'(req_ready), 32'h4);
        tick();
        chk("mid_in_exec", 32'(busy), 1);
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
`ifdef ALU_SCHED_OPCNT_EN
        cnt_m = 0;
`endif
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_resp", 32'(resp_valid), 0);
            chk("mid_not_busy", 32'(busy), 0);
            tick();
        end
        chk("mid_alu_a_clr", 32'(alu_a_out), 0);
        set_op(1, 4'h5, 4'hB, 3'd2);
        set_op(2, 4'hE, 4'h9, 3'd7);
        chk("mid_next_grant", 32'(rr_pick(4'b0110, ptr_m)), 1);
        serve(4'b0110, 4'hF, 0);
        req_valid = '0;

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                set_op(i, DW'($urandom), DW'($urandom), OW'($urandom));
            end
            serve(N'($urandom_range(1, 15)), N'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                req_valid = '0;
                tick();
                chk("rand_gap_ready", 32'(req_ready), 0);
            end
        end
        req_valid = '0;

`ifdef ALU_SCHED_OPCNT_EN
        // Counter: three ops from reset, then saturation from 0xFFFE.
        do_reset();
        for (int i = 0; i < 3; i++) serve(4'b1000, 4'hF, 0);
        chk("opcnt_three", 32'(op_count), 3);
        req_valid = '0;
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        cnt_m = 16'hFFFE;
        for (int i = 0; i < 3; i++) serve(4'b0001, 4'hF, 0);
        chk("opcnt_sat", 32'(op_count), 32'hFFFF);
        req_valid = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
